aes_ctr_stream: RTL and testbench
=================================

Name: aes_ctr_stream

Overview:
- Upstream/downstream companion to aes_encrypt_top, turning the single-block encryption core into an AES-CTR stream cipher.
- Accepts 128-bit data blocks on a valid/ready input stream.
- For each block, it drives the core with the current counter block, XORs the returned keystream with the data, and emits the result on a valid/ready output stream.
- Holds key, mode and IV configuration, and owns counter generation.

Parameters:
- CTR_WIDTH, 32: number of low-order counter bits that increment. Upper 128-CTR_WIDTH bits stay fixed at the IV value. Legal range 8..128.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_load  in  1  one-cycle pulse; latch cfg_mode, cfg_key, cfg_iv
- cfg_mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
- cfg_key  in  256  key, right-justified and zero-padded as the core expects
- cfg_iv  in  128  initial counter block
- s_valid  in  1  input block valid
- s_ready  out  1  input block accepted when s_valid&s_ready
- s_data  in  128  plaintext/ciphertext block
- s_last  in  1  final block of message
- m_valid  out  1  output block valid
- m_ready  in  1  downstream ready
- m_data  out  128  s_data XOR keystream
- m_last  out  1  copy of s_last for this block
- core_start  out  1  one-cycle start pulse to aes_encrypt_top
- core_mode  out  2  registered mode to core
- core_key  out  256  registered key to core
- core_block  out  128  counter block (core plaintext)
- core_result  in  128  core ciphertext (keystream)
- core_done  in  1  core completion level
- cfg_valid  out  1  legal configuration loaded
- busy  out  1  FSM not IDLE
- err_mode  out  1  sticky: cfg_load seen with cfg_mode=11

Behaviour:
- Reset values (rst low, asynchronous): all outputs 0; FSM=IDLE; key, iv, counter, data and mode registers = 0; done_q=0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- cfg_load in IDLE:
  - Legal mode: latch mode/key/iv, set counter=cfg_iv, set cfg_valid=1.
  - Mode 11: registers unchanged; err_mode set and held until reset.
- cfg_load outside IDLE is ignored entirely (no err_mode).
- IDLE:
  - s_ready = cfg_valid. s_ready is 0 in every other state.
  - On s_valid&s_ready: latch s_data and s_last, then go to ISSUE.
  - cfg_load in the same cycle as the accept is ignored.
- ISSUE (exactly one cycle): core_start=1, core_block=counter; next state WAIT.
- WAIT:
  - done_q registers core_done every cycle.
  - Completion requires a rising edge: core_done=1 and done_q=0.
  - A level left high from the previous block is never taken as completion.
  - On completion: m_data <= data_reg ^ core_result, m_last <= last_reg, m_valid <= 1.
  - Counter low CTR_WIDTH bits increment by 1, modulo 2^CTR_WIDTH; upper bits are untouched.
  - Next state OUT.
- OUT:
  - m_valid, m_data and m_last are held stable until m_ready.
  - On m_valid&m_ready: m_valid <= 0.
  - If m_last: counter <= iv (next message restarts at IV).
  - Next state IDLE.
- core_done outside WAIT is ignored.
- core_block, core_key and core_mode are registered and stable from ISSUE through completion.
- Latency:
  - Input accept at cycle T → core_start at T+1.
  - Core done edge at cycle D → m_valid at D+1.
- Throughput is one block per (core latency + 3) cycles.
- Counter wrap: the low field going all-ones→0 is silent (no flag). The upper field does not carry.
- Reset mid-operation: FSM returns to IDLE immediately; any in-flight output is discarded; cfg_valid=0, so reconfiguration is required.
- busy=1 in ISSUE, WAIT and OUT.

Test Plan:
- Single block, NIST SP800-38A F.5.1:
  - Stimulus: mode=00, key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, s_data 6bc1bee22e409f96e93d7e117393172a, s_last=1.
  - Required: core_block equals iv; m_data=874d6191b620e3261bef6864990db6ce, m_last=1.
- Counter step and restart:
  - Stimulus: same config, three blocks, last on the third.
  - Required: core_block ends …fcfdfeff, …fcfdff00, …fcfdff01. The next message's first core_block equals iv again.
- Wrap:
  - Stimulus: iv=0000…00_ffffffff, CTR_WIDTH=32, two blocks.
  - Required: second core_block = 0000…00_00000000, with the upper 96 bits unchanged.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid.
  - Required: m_data/m_last stable; s_ready=0; no extra core_start; accept resumes the cycle after the m handshake.
- Stale done:
  - Stimulus: core model keeps core_done high between blocks.
  - Required: the second block completes only on a fresh rising edge; exactly one m_valid per input block.
- Illegal config and reset:
  - cfg_load with mode=11 → err_mode=1, cfg_valid=0, s_ready=0.
  - rst low during WAIT → all outputs 0 asynchronously; after release, s_ready=0 until a legal cfg_load.

Source files
------------

// File: rtl/aes_ctr_stream_if.sv
// aes_ctr_stream_if: 128-bit valid/ready block stream with end-of-message marker.
interface aes_ctr_stream_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;
    logic         last;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-CTR wrapper around a single-block encryption core; owns
// key/mode/IV configuration, counter generation and keystream XOR.
module aes_ctr_stream #(
    parameter int CTR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_load_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [255:0]          cfg_key_i,
    input  logic [127:0]          cfg_iv_i,
    aes_ctr_stream_if.slave       s_if,
    aes_ctr_stream_if.master      m_if,
    output logic                  core_start_o,
    output logic [1:0]            core_mode_o,
    output logic [255:0]          core_key_o,
    output logic [127:0]          core_block_o,
    input  logic [127:0]          core_result_i,
    input  logic                  core_done_i,
    output logic                  cfg_valid_o,
    output logic                  busy_o,
    output logic                  err_mode_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
    // Only the low CTR_WIDTH bits of the counter block increment; the rest never carry.
    localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? '1 : ((128'd1 << CTR_WIDTH) - 128'd1);
    state_t         state_q;
    logic [1:0]     mode_q;
    logic [255:0]   key_q;
    logic [127:0]   iv_q, ctr_q, ctr_d, data_q, m_data_q;
    logic           last_q, m_last_q, m_valid_q, start_q, done_q, cfg_valid_q, err_q;
    logic           accept;
    assign accept = s_if.valid && s_if.ready;
    assign ctr_d  = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            key_q       <= '0;
            iv_q        <= '0;
            ctr_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= core_done_i;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= s_if.data;
                        last_q  <= s_if.last;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end else if (cfg_load_i) begin
                        if (cfg_mode_i == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q      <= cfg_mode_i;
                            key_q       <= cfg_key_i;
                            iv_q        <= cfg_iv_i;
                            ctr_q       <= cfg_iv_i;
                            cfg_valid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done level left over from the previous block is not a completion.
                    if (core_done_i && !done_q) begin
                        m_data_q  <= data_q ^ core_result_i;
                        m_last_q  <= last_q;
                        m_valid_q <= 1'b1;
                        ctr_q     <= ctr_d;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (m_if.ready) begin
                        m_valid_q <= 1'b0;
                        ctr_q     <= m_last_q ? iv_q : ctr_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign s_if.ready   = (state_q == IDLE) && cfg_valid_q;
    assign m_if.valid   = m_valid_q;
    assign m_if.data    = m_data_q;
    assign m_if.last    = m_last_q;
    assign core_start_o = start_q;
    assign core_mode_o  = mode_q;
    assign core_key_o   = key_q;
    assign core_block_o = ctr_q;
    assign cfg_valid_o  = cfg_valid_q;
    assign busy_o       = state_q != IDLE;
    assign err_mode_o   = err_q;
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed bench for aes_ctr_stream with a behavioural
// encryption core returning NIST SP800-38A F.5.1 keystream for known blocks.
module tb_aes_ctr_stream;
    localparam int LAT = 4;
    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] IV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] C1   = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2   = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] C3   = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    localparam logic [127:0] KX   = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic         cfg_load = 1'b0;
    logic [1:0]   cfg_mode = 2'b00;
    logic [255:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         core_start, core_done, cfg_valid, busy, err_mode;
    logic [1:0]   core_mode;
    logic [255:0] core_key;
    logic [127:0] core_block, core_result;
    aes_ctr_stream_if s_if();
    aes_ctr_stream_if m_if();
    aes_ctr_stream #(.CTR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_load_i(cfg_load), .cfg_mode_i(cfg_mode), .cfg_key_i(cfg_key), .cfg_iv_i(cfg_iv),
        .s_if(s_if), .m_if(m_if),
        .core_start_o(core_start), .core_mode_o(core_mode), .core_key_o(core_key),
        .core_block_o(core_block), .core_result_i(core_result), .core_done_i(core_done),
        .cfg_valid_o(cfg_valid), .busy_o(busy), .err_mode_o(err_mode)
    );
    int errors = 0;
    int checks = 0;
    logic stale = 1'b0;
    int starts = 0;
    int mv_rise = 0;
    logic [127:0] blks[$];
    function automatic logic [127:0] ks(input logic [127:0] b);
        case (b)
            IV:      ks = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
            IV1:     ks = 128'h362b7c3c6773516318a077d7fc5073ae;
            IV2:     ks = 128'h6a2cc3787889374fbeb4c81b17ba6c44;
            default: ks = b ^ KX;
        endcase
    endfunction
    // Core model: in stale mode done stays high between blocks and drops late.
    initial begin
        logic [127:0] blk;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                blk = core_block;
                blks.push_back(blk);
                starts++;
                if (stale) repeat (2) @(negedge clk);
                core_done = 1'b0;
                repeat (LAT) @(negedge clk);
                core_result = ks(blk);
                core_done = 1'b1;
                if (!stale) begin
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (m_if.valid === 1'b1 && !prev) mv_rise++;
            prev = (m_if.valid === 1'b1);
        end
    end
    task automatic cfg(input logic [1:0] mode, input logic [255:0] key, input logic [127:0] iv);
        cfg_mode = mode;
        cfg_key = key;
        cfg_iv = iv;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask
    task automatic send(input logic [127:0] d, input logic l);
        int n = 0;
        s_if.valid = 1'b1;
        s_if.data = d;
        s_if.last = l;
        while (s_if.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout s_ready=%b required 1", s_if.ready);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
    endtask
    task automatic recv(output logic [127:0] d, output logic l);
        int n = 0;
        while (m_if.valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL recv_timeout m_valid=%b required 1", m_if.valid);
        end
        d = m_if.data;
        l = m_if.last;
        m_if.ready = 1'b1;
        @(negedge clk);
        m_if.ready = 1'b0;
    endtask
    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({s_if.ready, m_if.valid, m_if.last, core_start, cfg_valid, busy, err_mode} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 0000000", {s_if.ready, m_if.valid, m_if.last, core_start, cfg_valid, busy, err_mode});
        end
        checks++;
        if (m_if.data !== '0 || core_block !== '0 || core_key !== '0 || core_mode !== 2'b00) begin
            errors++;
            $display("FAIL reset_data m_data=%h core_block=%h required 0", m_if.data, core_block);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_noready s_ready=%b required 0", s_if.ready);
        end
    endtask
    task automatic test_nist_single;
        logic [127:0] d;
        logic l;
        cfg(2'b00, {128'h0, KEY}, IV);
        checks++;
        if (cfg_valid !== 1'b1 || s_if.ready !== 1'b1 || core_key !== {128'h0, KEY} || core_mode !== 2'b00) begin
            errors++;
            $display("FAIL cfg_load cfg_valid=%b s_ready=%b mode=%b required 1 1 00", cfg_valid, s_if.ready, core_mode);
        end
        send(P1, 1'b1);
        checks++;
        if (core_start !== 1'b1 || busy !== 1'b1 || core_block !== IV) begin
            errors++;
            $display("FAIL issue start=%b busy=%b block=%h required 1 1 %h", core_start, busy, core_block, IV);
        end
        @(negedge clk);
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse start=%b required 0", core_start);
        end
        recv(d, l);
        checks++;
        if (d !== C1 || l !== 1'b1) begin
            errors++;
            $display("FAIL nist_single m_data=%h last=%b required %h 1", d, l, C1);
        end
    endtask
    task automatic test_counter;
        logic [127:0] d;
        logic l;
        int b0 = blks.size();
        send(P1, 1'b0);
        recv(d, l);
        checks++;
        if (d !== C1 || l !== 1'b0) begin
            errors++;
            $display("FAIL ctr_blk1 m_data=%h last=%b required %h 0", d, l, C1);
        end
        send(P2, 1'b0);
        recv(d, l);
        checks++;
        if (d !== C2 || l !== 1'b0) begin
            errors++;
            $display("FAIL ctr_blk2 m_data=%h last=%b required %h 0", d, l, C2);
        end
        send(P3, 1'b1);
        recv(d, l);
        checks++;
        if (d !== C3 || l !== 1'b1) begin
            errors++;
            $display("FAIL ctr_blk3 m_data=%h last=%b required %h 1", d, l, C3);
        end
        send(P1, 1'b1);
        recv(d, l);
        checks++;
        if (d !== C1) begin
            errors++;
            $display("FAIL ctr_restart_data m_data=%h required %h", d, C1);
        end
        checks++;
        if (blks.size() != b0 + 4 || blks[b0] !== IV || blks[b0+1] !== IV1 || blks[b0+2] !== IV2 || blks[b0+3] !== IV) begin
            errors++;
            $display("FAIL ctr_blocks count=%0d last=%h required %0d %h", blks.size() - b0, blks[blks.size()-1], 4, IV);
        end
    endtask
    task automatic test_wrap;
        logic [127:0] d;
        logic l;
        int b0 = blks.size();
        cfg(2'b00, {128'h0, KEY}, 128'h000000000000000000000000ffffffff);
        send('0, 1'b0);
        recv(d, l);
        checks++;
        if (d !== 128'ha5a5a5a5a5a5a5a5a5a5a5a55a5a5a5a) begin
            errors++;
            $display("FAIL wrap_blk1 m_data=%h required a5a5a5a5a5a5a5a5a5a5a5a55a5a5a5a", d);
        end
        send('0, 1'b1);
        recv(d, l);
        checks++;
        if (d !== KX || blks[b0+1] !== '0) begin
            errors++;
            $display("FAIL wrap_zero block=%h m_data=%h required 0 %h", blks[b0+1], d, KX);
        end
        cfg(2'b00, {128'h0, KEY}, 128'h112233445566778899aabbccffffffff);
        send('0, 1'b0);
        recv(d, l);
        send('0, 1'b1);
        recv(d, l);
        checks++;
        if (blks[b0+3] !== 128'h112233445566778899aabbcc00000000) begin
            errors++;
            $display("FAIL wrap_upper block=%h required 112233445566778899aabbcc00000000", blks[b0+3]);
        end
    endtask
    task automatic test_backpressure;
        logic [127:0] d;
        logic l;
        int n = 0;
        int st0;
        cfg(2'b00, {128'h0, KEY}, IV);
        send(P1, 1'b0);
        s_if.valid = 1'b1;
        s_if.data = P2;
        s_if.last = 1'b1;
        while (m_if.valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL bp_timeout m_valid=%b required 1", m_if.valid);
        end
        st0 = starts;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_if.valid !== 1'b1 || s_if.ready !== 1'b0 || m_if.data !== C1 || m_if.last !== 1'b0 || starts != st0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d m_valid=%b s_ready=%b m_data=%h starts=%0d required 1 0 %h %0d", i, m_if.valid, s_if.ready, m_if.data, starts, C1, st0);
            end
            cfg_mode = 2'b11;
            cfg_load = (i == 4);
            @(negedge clk);
        end
        cfg_load = 1'b0;
        checks++;
        if (err_mode !== 1'b0) begin
            errors++;
            $display("FAIL bp_cfg_ignored err_mode=%b required 0", err_mode);
        end
        m_if.ready = 1'b1;
        @(negedge clk);
        m_if.ready = 1'b0;
        checks++;
        if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume m_valid=%b s_ready=%b required 0 1", m_if.valid, s_if.ready);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        checks++;
        if (core_start !== 1'b1 || core_block !== IV1) begin
            errors++;
            $display("FAIL bp_next_issue start=%b block=%h required 1 %h", core_start, core_block, IV1);
        end
        recv(d, l);
        checks++;
        if (d !== C2 || l !== 1'b1) begin
            errors++;
            $display("FAIL bp_blk2 m_data=%h last=%b required %h 1", d, l, C2);
        end
    endtask
    task automatic test_stale_done;
        logic [127:0] d;
        logic l;
        int m0;
        stale = 1'b1;
        cfg(2'b00, {128'h0, KEY}, IV);
        m0 = mv_rise;
        send(P1, 1'b0);
        recv(d, l);
        checks++;
        if (d !== C1) begin
            errors++;
            $display("FAIL stale_blk1 m_data=%h required %h", d, C1);
        end
        send(P2, 1'b1);
        recv(d, l);
        checks++;
        if (d !== C2) begin
            errors++;
            $display("FAIL stale_blk2 m_data=%h required %h", d, C2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mv_rise - m0 != 2) begin
            errors++;
            $display("FAIL stale_count m_valid_pulses=%0d required 2", mv_rise - m0);
        end
        stale = 1'b0;
    endtask
    task automatic test_illegal_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cfg(2'b11, {128'h0, KEY}, IV);
        checks++;
        if (err_mode !== 1'b1 || cfg_valid !== 1'b0 || s_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mode err=%b cfg_valid=%b s_ready=%b required 1 0 0", err_mode, cfg_valid, s_if.ready);
        end
        cfg(2'b10, {128'h1, KEY}, IV);
        checks++;
        if (cfg_valid !== 1'b1 || core_mode !== 2'b10 || err_mode !== 1'b1) begin
            errors++;
            $display("FAIL legal_after_err cfg_valid=%b mode=%b err=%b required 1 10 1", cfg_valid, core_mode, err_mode);
        end
        send(P1, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_state busy=%b m_valid=%b required 1 0", busy, m_if.valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_if.ready, m_if.valid, core_start, cfg_valid, busy, err_mode} !== 6'b0 || core_block !== '0 || core_key !== '0 || m_if.data !== '0) begin
            errors++;
            $display("FAIL async_reset flags=%b block=%h required 000000 0", {s_if.ready, m_if.valid, core_start, cfg_valid, busy, err_mode}, core_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc=%0d s_ready=%b m_valid=%b busy=%b required 0 0 0", i, s_if.ready, m_if.valid, busy);
            end
        end
        cfg(2'b00, {128'h0, KEY}, IV);
        checks++;
        if (s_if.ready !== 1'b1 || err_mode !== 1'b0) begin
            errors++;
            $display("FAIL reconfig s_ready=%b err=%b required 1 0", s_if.ready, err_mode);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
    initial begin
        s_if.valid = 1'b0;
        s_if.data = '0;
        s_if.last = 1'b0;
        m_if.ready = 1'b0;
        test_reset();
        test_nist_single();
        test_counter();
        test_wrap();
        test_backpressure();
        test_stale_done();
        test_illegal_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
